// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: FSM states, forwarding selects
// and the default register-file address width.
package pipe_pkg;

  localparam int DEF_RF_AW = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding mux select for one ALU source register.
// The younger MEM-stage result wins over the WB-stage result; x0 is never forwarded.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int RF_AW = DEF_RF_AW
) (
  input  logic [RF_AW-1:0] ex_rs,
  input  logic [RF_AW-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic [RF_AW-1:0] wb_rd,
  input  logic             wb_regwrite,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_RF;
    if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard control for a 5-stage pipeline: memory-wait freeze with timeout fault,
// branch redirect flush, load-use stall, operand forwarding and a stall counter.
module pipeline_hazard_unit
  import pipe_pkg::*;
#(
  parameter int RF_AW       = DEF_RF_AW,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [RF_AW-1:0] DEC_RS1,
  input  logic [RF_AW-1:0] DEC_RS2,
  input  logic             DEC_USES_RS1,
  input  logic             DEC_USES_RS2,
  input  logic [RF_AW-1:0] EX_RS1,
  input  logic [RF_AW-1:0] EX_RS2,
  input  logic [RF_AW-1:0] EX_RD,
  input  logic             EX_REGWRITE,
  input  logic             EX_MEMREAD,
  input  logic [RF_AW-1:0] MEM_RD,
  input  logic             MEM_REGWRITE,
  input  logic [RF_AW-1:0] WB_RD,
  input  logic             WB_REGWRITE,
  input  logic             BR_TAKEN,
  input  logic             MEM_REQ,
  input  logic             MEM_READY,
  output logic             PC_WRITE,
  output logic             FD_EN,
  output logic             DE_EN,
  output logic             EM_EN,
  output logic             MW_EN,
  output logic             FD_FLUSH,
  output logic             DE_FLUSH,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic             MEM_FAULT,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_CYC);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] wait_inc;
  logic       freeze;
  logic       load_use;
  fwd_sel_t   fwd_a, fwd_b;

  // Loads always write a register, so the hazard check keys on EX_MEMREAD alone.
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = EX_REGWRITE;

  // Memory handshake: MEM_REQ is held by the MEM stage until a cycle in which
  // MEM_READY=1; that cycle completes the access and the pipeline may advance.
  assign freeze = (MEM_REQ && !MEM_READY)
                || ((state_q == ST_MEM_WAIT) && !MEM_READY)
                || (state_q == ST_FAULT);

  assign load_use = EX_MEMREAD && (EX_RD != '0)
                  && ((DEC_USES_RS1 && (DEC_RS1 == EX_RD))
                   || (DEC_USES_RS2 && (DEC_RS2 == EX_RD)));

  assign wait_inc = wait_q + 8'd1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_RUN: begin
        if (MEM_REQ && !MEM_READY) begin
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (MEM_READY) begin
          state_d = ST_RUN;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_V) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Priority: freeze > redirect > load-use.
  always_comb begin
    PC_WRITE = 1'b1;
    FD_EN    = 1'b1;
    DE_EN    = 1'b1;
    EM_EN    = 1'b1;
    MW_EN    = 1'b1;
    FD_FLUSH = 1'b0;
    DE_FLUSH = 1'b0;
    if (freeze) begin
      PC_WRITE = 1'b0;
      FD_EN    = 1'b0;
      DE_EN    = 1'b0;
      EM_EN    = 1'b0;
      MW_EN    = 1'b0;
    end else if (BR_TAKEN) begin
      FD_FLUSH = 1'b1;
      DE_FLUSH = 1'b1;
    end else if (load_use) begin
      PC_WRITE = 1'b0;
      FD_EN    = 1'b0;
      DE_FLUSH = 1'b1;
    end
  end

  assign MEM_FAULT = (state_q == ST_FAULT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      STALL_CNT <= '0;
    end else if (!PC_WRITE && (STALL_CNT != '1)) begin
      STALL_CNT <= STALL_CNT + CNT_W'(1);
    end
  end

  fwd_select #(.RF_AW(RF_AW)) u_fwd_a (
    .ex_rs        (EX_RS1),
    .mem_rd       (MEM_RD),
    .mem_regwrite (MEM_REGWRITE),
    .wb_rd        (WB_RD),
    .wb_regwrite  (WB_REGWRITE),
    .sel          (fwd_a)
  );

  fwd_select #(.RF_AW(RF_AW)) u_fwd_b (
    .ex_rs        (EX_RS2),
    .mem_rd       (MEM_RD),
    .mem_regwrite (MEM_REGWRITE),
    .wb_rd        (WB_RD),
    .wb_regwrite  (WB_REGWRITE),
    .sel          (fwd_b)
  );

  assign FWD_A_SEL = fwd_a;
  assign FWD_B_SEL = fwd_b;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: a vector table of single-cycle cases
// followed by hand-written multi-cycle sequences (stall count, wait, timeout, saturation).
module tb_pipeline_hazard_unit;

  localparam int RF_AW = 5;
  localparam int CNT_W = 4;
  localparam int W     = 12;

  // control word order: PC_WRITE, FD_EN, DE_EN, EM_EN, MW_EN, FD_FLUSH, DE_FLUSH
  localparam logic [6:0] C_NORM = 7'b1111100;
  localparam logic [6:0] C_LU   = 7'b0011101;
  localparam logic [6:0] C_REDR = 7'b1111111;
  localparam logic [6:0] C_FRZ  = 7'b0000000;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [RF_AW-1:0] DEC_RS1, DEC_RS2, EX_RS1, EX_RS2, EX_RD, MEM_RD, WB_RD;
  logic             DEC_USES_RS1, DEC_USES_RS2, EX_REGWRITE, EX_MEMREAD;
  logic             MEM_REGWRITE, WB_REGWRITE, BR_TAKEN, MEM_REQ, MEM_READY;
  logic             PC_WRITE, FD_EN, DE_EN, EM_EN, MW_EN, FD_FLUSH, DE_FLUSH, MEM_FAULT;
  logic [1:0]       FWD_A_SEL, FWD_B_SEL;
  logic [CNT_W-1:0] STALL_CNT;
  logic [W-1:0]     act_out;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    string            name;
    logic [RF_AW-1:0] dec_rs1, dec_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic             uses1, uses2, ex_memread, mem_rw, wb_rw, br, req, rdy;
    logic [6:0]       ctl;
    logic [1:0]       fa, fb;
  } vec_t;

  vec_t vecs[$];

  pipeline_hazard_unit #(.RF_AW(RF_AW), .TIMEOUT_CYC(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2),
    .DEC_USES_RS1(DEC_USES_RS1), .DEC_USES_RS2(DEC_USES_RS2),
    .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD),
    .EX_REGWRITE(EX_REGWRITE), .EX_MEMREAD(EX_MEMREAD),
    .MEM_RD(MEM_RD), .MEM_REGWRITE(MEM_REGWRITE),
    .WB_RD(WB_RD), .WB_REGWRITE(WB_REGWRITE),
    .BR_TAKEN(BR_TAKEN), .MEM_REQ(MEM_REQ), .MEM_READY(MEM_READY),
    .PC_WRITE(PC_WRITE), .FD_EN(FD_EN), .DE_EN(DE_EN), .EM_EN(EM_EN), .MW_EN(MW_EN),
    .FD_FLUSH(FD_FLUSH), .DE_FLUSH(DE_FLUSH),
    .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL),
    .MEM_FAULT(MEM_FAULT), .STALL_CNT(STALL_CNT)
  );

  assign act_out = {PC_WRITE, FD_EN, DE_EN, EM_EN, MW_EN, FD_FLUSH, DE_FLUSH,
                    FWD_A_SEL, FWD_B_SEL, MEM_FAULT};

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic add_vec(input string n,
                         input int d1, input int d2, input logic u1, input logic u2,
                         input int e1, input int e2, input int erd, input logic emr,
                         input int mrd, input logic mrw, input int wrd, input logic wrw,
                         input logic br, input logic req, input logic rdy,
                         input logic [6:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.name = n;
    v.dec_rs1 = RF_AW'(d1); v.dec_rs2 = RF_AW'(d2); v.uses1 = u1; v.uses2 = u2;
    v.ex_rs1 = RF_AW'(e1); v.ex_rs2 = RF_AW'(e2); v.ex_rd = RF_AW'(erd); v.ex_memread = emr;
    v.mem_rd = RF_AW'(mrd); v.mem_rw = mrw; v.wb_rd = RF_AW'(wrd); v.wb_rw = wrw;
    v.br = br; v.req = req; v.rdy = rdy; v.ctl = ctl; v.fa = fa; v.fb = fb;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    DEC_RS1 = v.dec_rs1; DEC_RS2 = v.dec_rs2;
    DEC_USES_RS1 = v.uses1; DEC_USES_RS2 = v.uses2;
    EX_RS1 = v.ex_rs1; EX_RS2 = v.ex_rs2; EX_RD = v.ex_rd;
    EX_REGWRITE = v.ex_memread; EX_MEMREAD = v.ex_memread;
    MEM_RD = v.mem_rd; MEM_REGWRITE = v.mem_rw;
    WB_RD = v.wb_rd; WB_REGWRITE = v.wb_rw;
    BR_TAKEN = v.br; MEM_REQ = v.req; MEM_READY = v.rdy;
  endtask

  task automatic drive_idle();
    DEC_RS1 = '0; DEC_RS2 = '0; DEC_USES_RS1 = 0; DEC_USES_RS2 = 0;
    EX_RS1 = '0; EX_RS2 = '0; EX_RD = '0; EX_REGWRITE = 0; EX_MEMREAD = 0;
    MEM_RD = '0; MEM_REGWRITE = 0; WB_RD = '0; WB_REGWRITE = 0;
    BR_TAKEN = 0; MEM_REQ = 0; MEM_READY = 0;
  endtask

  task automatic drive_mem(input logic req, input logic rdy);
    drive_idle();
    MEM_REQ = req;
    MEM_READY = rdy;
  endtask

  task automatic drive_load_use(input logic br);
    drive_idle();
    EX_MEMREAD = 1; EX_REGWRITE = 1; EX_RD = 5'd5;
    DEC_RS1 = 5'd5; DEC_USES_RS1 = 1;
    BR_TAKEN = br;
  endtask

  task automatic pulse_reset();
    RST = 0;
    #1;
    RST = 1;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [6:0] ctl,
                            input logic [1:0] fa, input logic [1:0] fb, input logic fault);
    logic [W-1:0] e;
    exp_q.push_back({ctl, fa, fb, fault});
    e = exp_q.pop_front();
    check(name, 32'(act_out), 32'(e));
  endtask

  initial begin
    // name        d1 d2 u1 u2 e1 e2 erd emr mrd mrw wrd wrw br req rdy ctl    fa fb
    add_vec("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0);
    add_vec("lu_rs1",     5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, C_LU,   0, 0);
    add_vec("lu_rs2",     1, 9, 1, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, C_LU,   0, 0);
    add_vec("lu_unused",  5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0);
    add_vec("lu_x0",      0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0);
    add_vec("lu_noload",  5, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0);
    add_vec("redir_lu",   5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0, C_REDR, 0, 0);
    add_vec("redir",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_REDR, 0, 0);
    add_vec("mem_frz",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  0, 0);
    add_vec("frz_all",    5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 1, 0, C_FRZ,  0, 0);
    add_vec("mem_ready",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORM, 0, 0);
    add_vec("fwd_mem_wb", 0, 0, 0, 0, 7, 0, 0, 0, 7, 1, 7, 1, 0, 0, 0, C_NORM, 1, 0);
    add_vec("fwd_wb",     0, 0, 0, 0, 7, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, C_NORM, 2, 0);
    add_vec("fwd_b_wb",   0, 0, 0, 0, 0, 3, 0, 0, 3, 0, 3, 1, 0, 0, 0, C_NORM, 0, 2);
    add_vec("fwd_ab_mem", 0, 0, 0, 0, 3, 3, 0, 0, 3, 1, 3, 1, 0, 0, 0, C_NORM, 1, 1);
    add_vec("fwd_x0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, C_NORM, 0, 0);
    add_vec("fwd_frz",    0, 0, 0, 0, 4, 6, 0, 0, 4, 1, 6, 1, 0, 1, 0, C_FRZ,  1, 2);

    drive_idle();
    RST = 0;
    repeat (2) @(negedge CLK);
    #1;
    check("reset_stall_cnt", 32'(STALL_CNT), 0);
    expect_out("reset_outputs", C_NORM, 2'd0, 2'd0, 1'b0);
    RST = 1;

    // table: reset before each vector so every case starts from RUN
    foreach (vecs[i]) begin
      @(negedge CLK);
      pulse_reset();
      drive(vecs[i]);
      #1;
      expect_out(vecs[i].name, vecs[i].ctl, vecs[i].fa, vecs[i].fb, 1'b0);
    end

    // load-use single stall, then redirect over a hazard does not stall
    @(negedge CLK);
    pulse_reset();
    drive_load_use(1'b0);
    #1;
    expect_out("seq_lu", C_LU, 2'd0, 2'd0, 1'b0);
    @(negedge CLK);
    drive_idle();
    #1;
    check("seq_lu_stall_cnt", 32'(STALL_CNT), 1);
    drive_load_use(1'b1);
    #1;
    expect_out("seq_redir_lu", C_REDR, 2'd0, 2'd0, 1'b0);
    @(negedge CLK);
    drive_idle();
    #1;
    check("seq_redir_no_stall", 32'(STALL_CNT), 1);

    // memory wait for 3 cycles, ready on the 4th
    pulse_reset();
    drive_mem(1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      expect_out($sformatf("wait_frz_%0d", c), C_FRZ, 2'd0, 2'd0, 1'b0);
      @(negedge CLK);
    end
    drive_mem(1'b1, 1'b1);
    #1;
    expect_out("wait_ready", C_NORM, 2'd0, 2'd0, 1'b0);
    @(negedge CLK);
    drive_mem(1'b0, 1'b0);
    #1;
    expect_out("wait_back_run", C_NORM, 2'd0, 2'd0, 1'b0);
    check("wait_stall_cnt", 32'(STALL_CNT), 3);

    // timeout after 4 MEM_WAIT cycles, sticky until async reset
    pulse_reset();
    drive_mem(1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    #1;
    check("timeout_not_yet", 32'(MEM_FAULT), 0);
    @(negedge CLK);
    #1;
    expect_out("timeout_fault", C_FRZ, 2'd0, 2'd0, 1'b1);
    drive_mem(1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    #1;
    expect_out("fault_sticky", C_FRZ, 2'd0, 2'd0, 1'b1);
    @(posedge CLK);
    #2;
    RST = 0;
    #1;
    expect_out("fault_async_clear", C_NORM, 2'd0, 2'd0, 1'b0);
    check("fault_reset_cnt", 32'(STALL_CNT), 0);
    RST = 1;

    // stall counter saturation over 20 stall cycles
    @(negedge CLK);
    pulse_reset();
    drive_mem(1'b1, 1'b0);
    repeat (14) @(negedge CLK);
    #1;
    check("sat_14", 32'(STALL_CNT), 14);
    repeat (6) @(negedge CLK);
    #1;
    check("sat_20", 32'(STALL_CNT), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
